// File: rtl/eda_output_mask_buf.sv
// Ping-pong regional-maxima mask buffer: one bank is written while the other
// streams out row by row over valid/ready, with a per-frame set-pixel count.
module eda_output_mask_buf #(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int I_WIDTH   = 2,
  parameter int CNT_WIDTH = $clog2(M*N+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 new_pixel,
  input  logic                 update_strb,
  input  logic                 compare_out,
  input  logic [M*N-1:0]       strb_value,
  input  logic                 frame_done,
  output logic                 wr_ready,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [I_WIDTH-1:0]   rd_row,
  output logic [N-1:0]         rd_data,
  output logic                 rd_last,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 count_valid,
  output logic                 overflow_err
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_st_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_st_t;

  bank_st_t             st [2];
  logic [M*N-1:0]       bank [2];
  logic [M*N-1:0]       wr_next;
  logic                 wr_sel;
  logic                 rd_sel;
  logic                 flag;
  logic [CNT_WIDTH-1:0] acc;
  rd_st_t               rd_state, rd_state_nxt;

  logic                 hs;
  logic                 last_hs;
  logic                 commit;
  logic                 other_free;
  logic                 full0;
  logic                 full1;
  logic [CNT_WIDTH-1:0] row_pop;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < N; b++) begin
      c = c + CNT_WIDTH'(v[b]);
    end
    return c;
  endfunction

  assign rd_valid = (rd_state == RD_STREAM);
  assign rd_data  = bank[rd_sel][int'(rd_row)*N +: N];
  assign rd_last  = rd_valid && (rd_row == I_WIDTH'(M-1));
  assign hs       = rd_valid && rd_ready;
  assign last_hs  = hs && (rd_row == I_WIDTH'(M-1));
  assign commit   = frame_done && wr_ready && !clear;
  assign full0    = (st[0] == B_FULL);
  assign full1    = (st[1] == B_FULL);
  assign row_pop  = popcount(rd_data);
  // The other bank counts as free if the reader releases it on this very edge.
  assign other_free = (st[!wr_sel] == B_FREE) || (last_hs && (rd_sel != wr_sel));

  always_comb begin
    wr_next = bank[wr_sel];
    for (int k = 0; k < M*N; k++) begin
      if (clear)
        wr_next[k] = 1'b1;
      else if (update_strb && strb_value[k])
        wr_next[k] = compare_out & flag;
      else if (strb_value[k])
        wr_next[k] = flag;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:   if (full0 || full1) rd_state_nxt = RD_STREAM;
      RD_STREAM: if (last_hs) rd_state_nxt = RD_IDLE;
      default:   rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rd_state <= RD_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank[0]      <= '1;
      bank[1]      <= '1;
      st[0]        <= B_FREE;
      st[1]        <= B_FREE;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      wr_ready     <= 1'b1;
      flag         <= 1'b1;
      rd_row       <= '0;
      acc          <= '0;
      frame_count  <= '0;
      count_valid  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      count_valid <= 1'b0;

      // ---- read side: claim a FULL bank, stream rows, release on last row
      if (rd_state == RD_IDLE) begin
        if (full0) begin
          rd_sel <= 1'b0;
          st[0]  <= B_READING;
          rd_row <= '0;
        end else if (full1) begin
          rd_sel <= 1'b1;
          st[1]  <= B_READING;
          rd_row <= '0;
        end
      end
      if (hs) begin
        if (last_hs) begin
          rd_row       <= '0;
          acc          <= '0;
          frame_count  <= acc + row_pop;
          count_valid  <= 1'b1;
          bank[rd_sel] <= '1;
          if (!wr_ready) begin
            st[rd_sel] <= B_FILLING;
            wr_sel     <= rd_sel;
            wr_ready   <= 1'b1;
          end else begin
            st[rd_sel] <= B_FREE;
          end
        end else begin
          rd_row <= rd_row + 1'b1;
          acc    <= acc + row_pop;
        end
      end

      // ---- write side: cell updates, region flag, commit and overflow
      if (clear || update_strb)
        flag <= 1'b1;
      else if (new_pixel && !compare_out)
        flag <= 1'b0;

      if (wr_ready)
        bank[wr_sel] <= wr_next;

      if (commit) begin
        st[wr_sel] <= B_FULL;
        flag       <= 1'b1;
        if (other_free) begin
          wr_sel      <= !wr_sel;
          st[!wr_sel] <= B_FILLING;
        end else begin
          wr_ready <= 1'b0;
        end
      end

      if (clear)
        overflow_err <= 1'b0;
      else if (frame_done && !wr_ready)
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eda_output_mask_buf.sv
// Directed bench for eda_output_mask_buf (M=N=4): expected rows and counts are
// queued at commit time and checked as the read port delivers them.
module tb_eda_output_mask_buf;

  localparam int M = 4;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int CW = $clog2(M*N+1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear, new_pixel, update_strb, compare_out, frame_done, rd_ready;
  logic [M*N-1:0] strb_value;
  logic          wr_ready, rd_valid, rd_last, count_valid, overflow_err;
  logic [IW-1:0] rd_row;
  logic [N-1:0]  rd_data;
  logic [CW-1:0] frame_count;

  typedef struct {
    logic [IW-1:0] row;
    logic [N-1:0]  data;
  } row_t;

  row_t        exp_q[$];
  int          cnt_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic        cv_prev = 1'b0;

  eda_output_mask_buf #(.M(M), .N(N), .I_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .new_pixel(new_pixel),
    .update_strb(update_strb), .compare_out(compare_out), .strb_value(strb_value),
    .frame_done(frame_done), .wr_ready(wr_ready), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_row(rd_row), .rd_data(rd_data), .rd_last(rd_last),
    .frame_count(frame_count), .count_valid(count_valid), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] r0, input logic [3:0] r1,
                            input logic [3:0] r2, input logic [3:0] r3, input int cnt);
    exp_q.push_back('{row: 2'd0, data: r0});
    exp_q.push_back('{row: 2'd1, data: r1});
    exp_q.push_back('{row: 2'd2, data: r2});
    exp_q.push_back('{row: 2'd3, data: r3});
    cnt_q.push_back(cnt);
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 200 && (exp_q.size() != 0 || cnt_q.size() != 0); c++) tick();
    chk(tag, 32'(exp_q.size() + cnt_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: every handshake and every count pulse pops an expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid && rd_ready) begin
        chk("row_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          row_t e;
          e = exp_q.pop_front();
          chk("rd_row", 32'(rd_row), 32'(e.row));
          chk("rd_data", 32'(rd_data), 32'(e.data));
          chk("rd_last", 32'(rd_last), 32'(e.row == 2'd3));
        end
      end
      if (count_valid) begin
        chk("cv_one_cycle", 32'(cv_prev), 32'd0);
        chk("cnt_expected", 32'(cnt_q.size() != 0), 32'd1);
        if (cnt_q.size() != 0) chk("frame_count", 32'(frame_count), 32'(cnt_q.pop_front()));
      end
    end
    cv_prev = count_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 0; new_pixel = 0; update_strb = 0; compare_out = 0;
    frame_done = 0; rd_ready = 0; strb_value = '0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_row", 32'(rd_row), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_count_valid", 32'(count_valid), 0);
    chk("rst_overflow", 32'(overflow_err), 0);

    // 1: untouched bank commits as all ones
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    frame_done = 1; tick(); frame_done = 0;
    rd_ready = 1;
    wait_drain("t1_drain");
    chk("t1_frame_count", 32'(frame_count), 16);

    // 2: candidate dropped then finalised non-max on (1,1),(1,2); check latency
    strb_value = 16'h0060; new_pixel = 1; compare_out = 0; tick();
    new_pixel = 0; update_strb = 1; compare_out = 1; tick();
    update_strb = 0; compare_out = 0; strb_value = '0;
    push_frame(4'hF, 4'b1001, 4'hF, 4'hF, 14);
    frame_done = 1; tick(); frame_done = 0;
    chk("t2_valid_t", 32'(rd_valid), 0);
    tick();
    chk("t2_valid_t1", 32'(rd_valid), 1);
    wait_drain("t2_drain");
    chk("t2_frame_count", 32'(frame_count), 14);

    // 3: backpressure holds row 0 stable
    rd_ready = 0;
    new_pixel = 1; tick(); new_pixel = 0;
    strb_value = 16'h0005; tick(); strb_value = '0;
    push_frame(4'hA, 4'hF, 4'hF, 4'hF, 14);
    frame_done = 1; tick(); frame_done = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(rd_valid), 1);
      chk("t3_hold_row", 32'(rd_row), 0);
      chk("t3_hold_data", 32'(rd_data), 32'hA);
      tick();
    end
    rd_ready = 1;
    wait_drain("t3_drain");

    // 4: two frames held, third commit dropped
    rd_ready = 0;
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    frame_done = 1; tick(); frame_done = 0;
    new_pixel = 1; tick(); new_pixel = 0;
    strb_value = 16'h0001; tick(); strb_value = '0;
    push_frame(4'hE, 4'hF, 4'hF, 4'hF, 15);
    frame_done = 1; tick();
    chk("t4_wr_ready_low", 32'(wr_ready), 0);
    tick(); frame_done = 0;
    chk("t4_overflow", 32'(overflow_err), 1);
    chk("t4_rd_valid", 32'(rd_valid), 1);
    rd_ready = 1;
    for (int c = 0; c < 20 && !(rd_valid && rd_last); c++) tick();
    chk("t4_reached_last", 32'(rd_valid && rd_last), 1);
    tick();
    chk("t4_wr_ready_back", 32'(wr_ready), 1);
    wait_drain("t4_drain");

    // 5: clear beats frame_done; clear mid-stream leaves read bank alone
    new_pixel = 1; tick(); new_pixel = 0;
    strb_value = 16'h0020; tick(); strb_value = '0;
    clear = 1; frame_done = 1; tick(); clear = 0; frame_done = 0;
    chk("t5_overflow_cleared", 32'(overflow_err), 0);
    for (int c = 0; c < 3; c++) begin
      chk("t5_no_commit", 32'(rd_valid), 0);
      tick();
    end
    rd_ready = 0;
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    frame_done = 1; tick(); frame_done = 0;
    tick();
    new_pixel = 1; tick(); new_pixel = 0;
    strb_value = '1; tick(); strb_value = '0;
    clear = 1; tick(); clear = 0;
    rd_ready = 1;
    wait_drain("t5_drain");

    // 6: reset mid-stream, then both banks must read back all ones
    rd_ready = 0;
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    frame_done = 1; tick(); frame_done = 0;
    new_pixel = 1; tick(); new_pixel = 0;
    strb_value = '1; tick(); strb_value = '0;
    rd_ready = 1;
    for (int c = 0; c < 20 && !(rd_valid && rd_row == 2'd2); c++) tick();
    chk("t6_reached_row2", 32'(rd_valid && rd_row == 2'd2), 1);
    reset_n = 0; rd_ready = 0;
    tick();
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_wr_ready", 32'(wr_ready), 1);
    chk("t6_rd_row", 32'(rd_row), 0);
    chk("t6_frame_count", 32'(frame_count), 0);
    chk("t6_count_valid", 32'(count_valid), 0);
    exp_q.delete();
    cnt_q.delete();
    reset_n = 1; tick();
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    push_frame(4'hF, 4'hF, 4'hF, 4'hF, 16);
    frame_done = 1; tick(); tick(); frame_done = 0;
    rd_ready = 1;
    wait_drain("t6_drain");
    chk("t6_final_count", 32'(frame_count), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
